// File: rtl/palette_ctrl.sv
// 8-entry colour palette: 3-bit pixel index -> registered 8-bit R/G/B.
// Host loads a shadow palette; a commit copies it to the active palette during vblank.
module palette_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [2:0]  pix_index,
  input  logic        blank,
  input  logic        vblank_start,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        pix_out_valid,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [2:0]  wr_addr,
  input  logic [23:0] wr_data,
  input  logic        commit_req,
  output logic        commit_busy,
  output logic        commit_done
);

  typedef enum logic [1:0] {IDLE, ARMED, COPY, DONE} state_e;

  // Power-up palette, entries packed as {b, g, r}.
  function automatic logic [23:0] default_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    default_entry = 24'h000000;
      3'd1:    default_entry = 24'h030326;
      3'd2:    default_entry = 24'h0a0a46;
      3'd3:    default_entry = 24'h38383a;
      3'd4:    default_entry = 24'h2d2621;
      3'd5:    default_entry = 24'h000000;
      3'd6:    default_entry = 24'h241211;
      default: default_entry = 24'h645f57;
    endcase
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [23:0] active_q [8];
  logic [23:0] active_d [8];
  logic [23:0] shadow_q [8];
  logic [23:0] shadow_d [8];
  logic [23:0] rgb_q, rgb_d;
  logic        pov_q, pov_d;

  assign wr_ready      = (state_q == IDLE);
  assign commit_busy   = (state_q != IDLE);
  assign commit_done   = (state_q == DONE);
  assign vga_r         = rgb_q[7:0];
  assign vga_g         = rgb_q[15:8];
  assign vga_b         = rgb_q[23:16];
  assign pix_out_valid = pov_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    shadow_d = shadow_q;
    rgb_d    = rgb_q;
    pov_d    = pix_valid;

    // Lookup reads the registered active palette, so a same-cycle copy yields the old entry.
    if (pix_valid) begin
      rgb_d = blank ? 24'h000000 : active_q[pix_index];
    end

    if (wr_valid && wr_ready) begin
      shadow_d[wr_addr] = wr_data;
    end

    case (state_q)
      IDLE: begin
        if (commit_req) state_d = ARMED;
      end
      ARMED: begin
        if (vblank_start) begin
          state_d = COPY;
          cnt_d   = 3'd0;
        end
      end
      COPY: begin
        active_d[cnt_q] = shadow_q[cnt_q];
        cnt_d           = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rgb_q   <= 24'h000000;
      pov_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        active_q[i] <= default_entry(3'(i));
        shadow_q[i] <= default_entry(3'(i));
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rgb_q    <= rgb_d;
      pov_q    <= pov_d;
      active_q <= active_d;
      shadow_q <= shadow_d;
    end
  end

endmodule
